y86_mem_arbiter: RTL and testbench

- Shares one single-port, 32-bit-word synchronous memory between two requesters:
  - the y86 instruction-fetch path, which needs 48-bit instruction bytes at any byte address;
  - the data load/store path, which makes word accesses.
- Sits between y86_cpu and the unified memory, replacing the dedicated instruction RAM.
- Sequences multi-word fetches, assembles the instruction bytes, and arbitrates round-robin when both requesters are pending.

---
 rtl/y86_mem_arbiter_if.sv | 35 +++
 rtl/y86_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_y86_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_mem_arbiter_if.sv
// Bus bundle between the y86 fetch/data requesters, the arbiter and the unified memory.
// slave = arbiter view; master = requesters plus memory (environment) view.
interface y86_mem_arbiter_if #(
    parameter int MEM_AW = 30
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ready;
    logic [47:0]       if_data;

    logic              dm_req;
    logic              dm_we;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ready;
    logic [31:0]       dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_data, dm_ready, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_data, dm_ready, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/y86_mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit synchronous memory between y86 fetch (48-bit, any byte
// address) and data word accesses. Define Y86_ARB_STATS_EN to add saturating activity counters.
module y86_mem_arbiter #(
    parameter int MEM_AW     = 30,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    y86_mem_arbiter_if.slave bus,
    output logic             busy
`ifdef Y86_ARB_STATS_EN
    ,
    output logic [15:0]      stat_fetch,
    output logic [15:0]      stat_data,
    output logic [15:0]      stat_conflict
`endif
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        F_ISSUE = 3'd1,
        F_CAP   = 3'd2,
        D_ISSUE = 3'd3,
        D_CAP   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;          // 1: data wins the next conflict
    logic              own_data_q, own_data_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        nlast_q, nlast_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [63:0]       fbuf_q, fbuf_d;
    logic [47:0]       if_data_q, if_data_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;

    logic              mem_en, mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              if_ready, dm_ready;
    logic              acc_fetch, acc_data, conflict;
    logic [95:0]       fcat;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{bus.dm_addr[1:0]};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            ptr_q      <= DATA_FIRST;
            own_data_q <= 1'b0;
            waddr_q    <= '0;
            off_q      <= '0;
            nlast_q    <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            fbuf_q     <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            own_data_q <= own_data_d;
            waddr_q    <= waddr_d;
            off_q      <= off_d;
            nlast_q    <= nlast_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            fbuf_q     <= fbuf_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        own_data_d = own_data_q;
        waddr_d    = waddr_q;
        off_d      = off_q;
        nlast_d    = nlast_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        fbuf_d     = fbuf_q;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if_ready   = 1'b0;
        dm_ready   = 1'b0;
        acc_fetch  = 1'b0;
        acc_data   = 1'b0;
        conflict   = 1'b0;
        fcat       = '0;

        case (state_q)
            IDLE: begin
                conflict = bus.if_req && bus.dm_req;
                acc_data = bus.dm_req && (!bus.if_req || ptr_q);
                acc_fetch = bus.if_req && !acc_data;
                if (acc_data) begin
                    ptr_d      = 1'b0;
                    own_data_d = 1'b1;
                    waddr_d    = bus.dm_addr[MEM_AW+1:2];
                    we_d       = bus.dm_we;
                    wdata_d    = bus.dm_wdata;
                    state_d    = D_ISSUE;
                end else if (acc_fetch) begin
                    ptr_d      = 1'b1;
                    own_data_d = 1'b0;
                    waddr_d    = bus.if_addr[MEM_AW+1:2];
                    off_d      = bus.if_addr[1:0];
                    nlast_d    = (bus.if_addr[1:0] == 2'd3) ? 2'd2 : 2'd1;
                    cnt_d      = '0;
                    state_d    = F_ISSUE;
                end
            end
            F_ISSUE: begin
                // Each cycle issues word cnt and captures the word issued the cycle before.
                mem_en   = 1'b1;
                mem_addr = waddr_q + MEM_AW'(cnt_q);
                if (cnt_q == 2'd1) fbuf_d[31:0]  = bus.mem_rdata;
                if (cnt_q == 2'd2) fbuf_d[63:32] = bus.mem_rdata;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == nlast_q) state_d = F_CAP;
            end
            F_CAP: begin
                if (nlast_q == 2'd2) fcat = {bus.mem_rdata, fbuf_q};
                else                 fcat = {32'h0, bus.mem_rdata, fbuf_q[31:0]};
                if_data_d = 48'(fcat >> {off_q, 3'b000});
                state_d   = DONE;
            end
            D_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = waddr_q;
                mem_wdata = wdata_q;
                state_d   = we_q ? DONE : D_CAP;
            end
            D_CAP: begin
                dm_rdata_d = bus.mem_rdata;
                state_d    = DONE;
            end
            DONE: begin
                if_ready = !own_data_q;
                dm_ready = own_data_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_ready  = if_ready;
    assign bus.if_data   = if_data_q;
    assign bus.dm_ready  = dm_ready;
    assign bus.dm_rdata  = dm_rdata_q;
    assign busy          = (state_q != IDLE);

`ifdef Y86_ARB_STATS_EN
    logic [15:0] sf_q, sd_q, sc_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sf_q <= '0;
            sd_q <= '0;
            sc_q <= '0;
        end else begin
            if (acc_fetch && sf_q != '1) sf_q <= sf_q + 16'd1;
            if (acc_data  && sd_q != '1) sd_q <= sd_q + 16'd1;
            if (conflict  && sc_q != '1) sc_q <= sc_q + 16'd1;
        end
    end

    assign stat_fetch    = sf_q;
    assign stat_data     = sd_q;
    assign stat_conflict = sc_q;
`endif
endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Self-checking bench for y86_mem_arbiter: table of single transactions plus hand-written
// conflict and mid-transaction reset sequences, with a scoreboard of expected completions.
module tb_y86_mem_arbiter;
    localparam int MEM_AW = 30;

    logic CLK = 1'b0;
    logic RESET_N;
    logic busy;
`ifdef Y86_ARB_STATS_EN
    logic [15:0] stat_fetch, stat_data, stat_conflict;
`endif

    y86_mem_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

    y86_mem_arbiter #(
        .MEM_AW    (MEM_AW),
        .DATA_FIRST(1'b1)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus),
        .busy   (busy)
`ifdef Y86_ARB_STATS_EN
        ,
        .stat_fetch   (stat_fetch),
        .stat_data    (stat_data),
        .stat_conflict(stat_conflict)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model: byte at address a reads a[7:0] unless a word below 64 was written.
    logic [31:0] wm [0:63];
    logic [63:0] wv;
    logic        mem_clr;

    function automatic logic [31:0] pat(input logic [29:0] w);
        logic [7:0] b;
        b = {w[5:0], 2'b00};
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always @(posedge CLK) begin
        if (mem_clr) begin
            wv <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                if (bus.mem_addr[29:6] == '0) begin
                    wm[bus.mem_addr[5:0]] <= bus.mem_wdata;
                    wv[bus.mem_addr[5:0]] <= 1'b1;
                end
            end else begin
                bus.mem_rdata <= (bus.mem_addr[29:6] == '0 && wv[bus.mem_addr[5:0]])
                                 ? wm[bus.mem_addr[5:0]] : pat(bus.mem_addr);
            end
        end
    end

    typedef struct {
        logic [47:0] data;
        bit          chk;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [47:0] exp;
        bit          chk;
        int unsigned lat;
        int unsigned nacc;
        logic [29:0] a0;
    } vec_t;

    exp_t        fq[$];
    exp_t        dq[$];
    logic [30:0] acc[$];
    logic [30:0] xacc[$];
    vec_t        vecs [10];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an unexpected ready pulse, expected none", name);
    endtask

    task automatic issue_fetch(input logic [31:0] a, input logic [47:0] d, input int unsigned c);
        exp_t e;
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        e.data = d;
        e.chk  = 1'b1;
        e.cyc  = c;
        fq.push_back(e);
    endtask

    task automatic issue_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input bit ck, input int unsigned c);
        exp_t e;
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = wd;
        bus.dm_req   = 1'b1;
        e.data = {16'h0, rd};
        e.chk  = ck;
        e.cyc  = c;
        dq.push_back(e);
    endtask

    task automatic log_acc();
        if (bus.mem_en) acc.push_back({bus.mem_we, bus.mem_addr});
    endtask

    task automatic service(input int unsigned budget);
        int unsigned cyc;
        exp_t        e;
        cyc = 0;
        while ((fq.size() != 0 || dq.size() != 0) && cyc < budget) begin
            @(posedge CLK);
            #1;
            cyc++;
            log_acc();
            if (cyc == 1) chk("busy_after_accept", 64'(busy), 64'd1);
            if (bus.if_ready) begin
                if (fq.size() == 0) fail("if_ready_spurious");
                else begin
                    e = fq.pop_front();
                    chk("if_data", 64'(bus.if_data), 64'(e.data));
                    chk("if_latency", 64'(cyc), 64'(e.cyc));
                end
                bus.if_req = 1'b0;
            end
            if (bus.dm_ready) begin
                if (dq.size() == 0) fail("dm_ready_spurious");
                else begin
                    e = dq.pop_front();
                    if (e.chk) chk("dm_rdata", 64'(bus.dm_rdata), 64'(e.data[31:0]));
                    chk("dm_latency", 64'(cyc), 64'(e.cyc));
                end
                bus.dm_req = 1'b0;
            end
        end
        if (fq.size() != 0 || dq.size() != 0) begin
            chk("timeout_pending", 64'(fq.size() + dq.size()), 64'd0);
            fq.delete();
            dq.delete();
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
        end
        @(posedge CLK);
        #1;
        log_acc();
        chk("single_ready_pulse", 64'({bus.if_ready, bus.dm_ready}), 64'd0);
    endtask

    task automatic check_log();
        chk("mem_access_count", 64'(acc.size()), 64'(xacc.size()));
        for (int j = 0; j < acc.size() && j < xacc.size(); j++)
            chk("mem_access_we_addr", 64'(acc[j]), 64'(xacc[j]));
        acc.delete();
        xacc.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 64'({bus.if_ready, bus.dm_ready, bus.mem_en, bus.mem_we, busy}), 64'd0);
        chk({tag, "_if_data"}, 64'(bus.if_data), 64'd0);
        chk({tag, "_dm_rdata"}, 64'(bus.dm_rdata), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    initial begin
        //          fetch we  addr           wdata          expected          chk lat nacc a0
        vecs[0] = '{1'b1, 1'b0, 32'h00000001, 32'h0,        48'h060504030201, 1'b1, 3, 2, 30'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h00000003, 32'h0,        48'h080706050403, 1'b1, 4, 3, 30'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h00000000, 32'h0,        48'h050403020100, 1'b1, 3, 2, 30'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h00000006, 32'h0,        48'h0B0A09080706, 1'b1, 3, 2, 30'h1};
        vecs[4] = '{1'b0, 1'b1, 32'h00000040, 32'hDEADBEEF, 48'h0,            1'b0, 1, 1, 30'h10};
        vecs[5] = '{1'b0, 1'b0, 32'h00000042, 32'h0,        48'hDEADBEEF,     1'b1, 2, 1, 30'h10};
        vecs[6] = '{1'b0, 1'b0, 32'h00000080, 32'h0,        48'h83828180,     1'b1, 2, 1, 30'h20};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFFFFFD, 32'h0,        48'h020100FFFEFD, 1'b1, 3, 2, 30'h3FFFFFFF};
        vecs[8] = '{1'b1, 1'b0, 32'h0000003F, 32'h0,        48'h44DEADBEEF3F, 1'b1, 4, 3, 30'hF};
        vecs[9] = '{1'b0, 1'b1, 32'h00000041, 32'h12345678, 48'h0,            1'b0, 1, 1, 30'h10};

        mem_clr      = 1'b1;
        RESET_N      = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        mem_clr = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_fetch)
                issue_fetch(vecs[i].addr, vecs[i].exp, vecs[i].lat + 1);
            else
                issue_data(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp[31:0],
                           vecs[i].chk, vecs[i].lat + 1);
            for (int unsigned j = 0; j < vecs[i].nacc; j++)
                xacc.push_back({vecs[i].we, vecs[i].a0 + 30'(j)});
            service(20);
            check_log();
        end

        chk("dm_rdata_hold", 64'(bus.dm_rdata), 64'h83828180);
        issue_fetch(32'h00000040, 48'h454412345678, 4);
        xacc.push_back({1'b0, 30'h10});
        xacc.push_back({1'b0, 30'h11});
        service(20);
        check_log();

        // Conflicts after reset: data first, then grants alternate with the pointer.
        @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        issue_data(1'b1, 32'h80, 32'hA5A5A5A5, 32'h0, 1'b0, 2);
        issue_fetch(32'h01, 48'h060504030201, 7);
        xacc.push_back({1'b1, 30'h20});
        xacc.push_back({1'b0, 30'h0});
        xacc.push_back({1'b0, 30'h1});
        service(30);
        check_log();

        issue_data(1'b0, 32'h80, 32'h0, 32'hA5A5A5A5, 1'b1, 3);
        issue_fetch(32'h05, 48'h0A0908070605, 8);
        xacc.push_back({1'b0, 30'h20});
        xacc.push_back({1'b0, 30'h1});
        xacc.push_back({1'b0, 30'h2});
        service(30);
        check_log();

        issue_data(1'b1, 32'h84, 32'h11223344, 32'h0, 1'b0, 2);
        xacc.push_back({1'b1, 30'h21});
        service(20);
        check_log();
        issue_data(1'b0, 32'h84, 32'h0, 32'h11223344, 1'b1, 8);
        issue_fetch(32'h84, 48'h898811223344, 4);
        xacc.push_back({1'b0, 30'h21});
        xacc.push_back({1'b0, 30'h22});
        xacc.push_back({1'b0, 30'h21});
        service(30);
        check_log();

        // Reset in the middle of a fetch aborts it without a ready pulse.
        bus.if_addr = 32'h03;
        bus.if_req  = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("mid_fetch_mem_en", 64'(bus.mem_en), 64'd1);
        RESET_N = 1'b0;
        #1;
        check_zero("async_reset");
        bus.if_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            chk("no_ready_in_reset", 64'({bus.if_ready, busy}), 64'd0);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        issue_fetch(32'h05, 48'h0A0908070605, 4);
        xacc.push_back({1'b0, 30'h1});
        xacc.push_back({1'b0, 30'h2});
        service(20);
        check_log();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
